// File: rtl/decode_index_fifo.sv
// Maps decoder one-hot-low code words to a 3-bit index (or error), queues results in a small
// valid/ready FIFO, and keeps saturating hit/error counters. `define DECODE_STICKY_ERR_EN adds err_sticky.
module decode_index_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] data_in,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       out_idx,
    output logic             out_err,
    input  logic [2:0]       cnt_sel,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] err_cnt
`ifdef DECODE_STICKY_ERR_EN
    ,
    output logic             err_sticky
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // The code words are decimal constants whose digits happen to look like a one-hot-low pattern.
    localparam logic [WIDTH-1:0] CODE_0 = WIDTH'(11111110);
    localparam logic [WIDTH-1:0] CODE_1 = WIDTH'(11111101);
    localparam logic [WIDTH-1:0] CODE_2 = WIDTH'(11111011);
    localparam logic [WIDTH-1:0] CODE_3 = WIDTH'(11110111);
    localparam logic [WIDTH-1:0] CODE_4 = WIDTH'(11101111);
    localparam logic [WIDTH-1:0] CODE_5 = WIDTH'(11011111);
    localparam logic [WIDTH-1:0] CODE_6 = WIDTH'(10111111);
    localparam logic [WIDTH-1:0] CODE_7 = WIDTH'(01111111);

    typedef struct packed {
        logic       err;
        logic [2:0] idx;
    } entry_t;

    entry_t           cls_entry;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    entry_t           mem_q [DEPTH];
    entry_t           mem_d [DEPTH];
    logic [CNT_W-1:0] hit_cnt_q [8];
    logic [CNT_W-1:0] hit_cnt_d [8];
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        cls_entry.idx = 3'd0;
        cls_entry.err = 1'b0;
        case (data_in)
            CODE_0:  cls_entry.idx = 3'd0;
            CODE_1:  cls_entry.idx = 3'd1;
            CODE_2:  cls_entry.idx = 3'd2;
            CODE_3:  cls_entry.idx = 3'd3;
            CODE_4:  cls_entry.idx = 3'd4;
            CODE_5:  cls_entry.idx = 3'd5;
            CODE_6:  cls_entry.idx = 3'd6;
            CODE_7:  cls_entry.idx = 3'd7;
            default: cls_entry.err = 1'b1;
        endcase
    end

    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q == {~rd_ptr_q[AW], rd_ptr_q[AW-1:0]});
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid && !full && (data_in != '0);
    assign pop       = !empty && out_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (push) begin
            mem_d[wr_ptr_q[AW-1:0]] = cls_entry;
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    always_comb begin
        hit_cnt_d = hit_cnt_q;
        err_cnt_d = err_cnt_q;
        if (push) begin
            if (cls_entry.err) begin
                if (err_cnt_q != CNT_MAX) err_cnt_d = err_cnt_q + CNT_W'(1);
            end else if (hit_cnt_q[cls_entry.idx] != CNT_MAX) begin
                hit_cnt_d[cls_entry.idx] = hit_cnt_q[cls_entry.idx] + CNT_W'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            err_cnt_q <= '0;
            for (int i = 0; i < 8; i++) hit_cnt_q[i] <= '0;
            // NOTE: the tiny FIFO array is reset so the head reads idx 0 / err 0 straight out of reset.
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            err_cnt_q <= err_cnt_d;
            hit_cnt_q <= hit_cnt_d;
            mem_q     <= mem_d;
        end
    end

    assign out_idx = mem_q[rd_ptr_q[AW-1:0]].idx;
    assign out_err = mem_q[rd_ptr_q[AW-1:0]].err;
    assign hit_cnt = hit_cnt_q[cnt_sel];
    assign err_cnt = err_cnt_q;

`ifdef DECODE_STICKY_ERR_EN
    logic err_sticky_q, err_sticky_d;

    always_comb begin
        err_sticky_d = err_sticky_q | (push && cls_entry.err);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) err_sticky_q <= 1'b0;
        else      err_sticky_q <= err_sticky_d;
    end

    assign err_sticky = err_sticky_q;
`endif

endmodule

// File: tb/tb_decode_index_fifo.sv
// Directed bench for decode_index_fifo: default instance plus a CNT_W=2 instance for saturation.
module tb_decode_index_fifo;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        in_valid, out_ready;
    logic [31:0] data_in;
    logic [2:0]  cnt_sel;
    logic        in_ready, out_valid, out_err;
    logic [2:0]  out_idx;
    logic [15:0] hit_cnt, err_cnt;

    logic        s_in_valid, s_out_ready;
    logic [31:0] s_data_in;
    logic [2:0]  s_cnt_sel;
    logic        s_in_ready, s_out_valid, s_out_err;
    logic [2:0]  s_out_idx;
    logic [1:0]  s_hit_cnt, s_err_cnt;

`ifdef DECODE_STICKY_ERR_EN
    logic        err_sticky, s_err_sticky;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] codes [8];

    always #10 clk = ~clk;

    decode_index_fifo dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .data_in(data_in), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx), .out_err(out_err),
        .cnt_sel(cnt_sel), .hit_cnt(hit_cnt), .err_cnt(err_cnt)
`ifdef DECODE_STICKY_ERR_EN
        , .err_sticky(err_sticky)
`endif
    );

    decode_index_fifo #(.WIDTH(32), .DEPTH(4), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .data_in(s_data_in), .in_ready(s_in_ready),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_idx(s_out_idx), .out_err(s_out_err),
        .cnt_sel(s_cnt_sel), .hit_cnt(s_hit_cnt), .err_cnt(s_err_cnt)
`ifdef DECODE_STICKY_ERR_EN
        , .err_sticky(s_err_sticky)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step();
        step();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready); end
        n_checks++; if (out_idx !== 3'd0) begin n_fail++; $display("FAIL reset_out_idx: got %0d expected 0", out_idx); end
        n_checks++; if (out_err !== 1'b0) begin n_fail++; $display("FAIL reset_out_err: got %0b expected 0", out_err); end
        n_checks++; if (err_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_err_cnt: got %0d expected 0", err_cnt); end
        for (int i = 0; i < 8; i++) begin
            cnt_sel = 3'(i);
            #1;
            n_checks++; if (hit_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_hit_cnt[%0d]: got %0d expected 0", i, hit_cnt); end
        end
`ifdef DECODE_STICKY_ERR_EN
        n_checks++; if (err_sticky !== 1'b0) begin n_fail++; $display("FAIL reset_err_sticky: got %0b expected 0", err_sticky); end
`endif
        rst = 1'b1;
    endtask

    task automatic test_first_push();
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        data_in   = 32'd11111110;
        step();
        in_valid = 1'b0;
        cnt_sel  = 3'd0;
        #1;
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL first_out_valid: got %0b expected 1", out_valid); end
        n_checks++; if (out_idx !== 3'd0) begin n_fail++; $display("FAIL first_out_idx: got %0d expected 0", out_idx); end
        n_checks++; if (out_err !== 1'b0) begin n_fail++; $display("FAIL first_out_err: got %0b expected 0", out_err); end
        n_checks++; if (hit_cnt !== 16'd1) begin n_fail++; $display("FAIL first_hit_cnt0: got %0d expected 1", hit_cnt); end
        out_ready = 1'b1;
        step();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL first_drain: got %0b expected 0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            data_in  = codes[i];
            step();
            n_checks++; if (out_valid !== 1'b1 || out_idx !== 3'(i) || out_err !== 1'b0) begin
                n_fail++; $display("FAIL b2b_head[%0d]: got v=%0b idx=%0d err=%0b expected v=1 idx=%0d err=0", i, out_valid, out_idx, out_err, i);
            end
        end
        in_valid = 1'b0;
        step();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got %0b expected 0", out_valid); end
        for (int i = 0; i < 8; i++) begin
            cnt_sel = 3'(i);
            #1;
            n_checks++; if (hit_cnt !== 16'd1) begin n_fail++; $display("FAIL b2b_hit_cnt[%0d]: got %0d expected 1", i, hit_cnt); end
        end
        n_checks++; if (err_cnt !== 16'd0) begin n_fail++; $display("FAIL b2b_err_cnt: got %0d expected 0", err_cnt); end
`ifdef DECODE_STICKY_ERR_EN
        n_checks++; if (err_sticky !== 1'b0) begin n_fail++; $display("FAIL b2b_err_sticky: got %0b expected 0", err_sticky); end
`endif
        out_ready = 1'b0;
    endtask

    task automatic test_errors();
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        data_in   = 32'd11111111;
        step();
        data_in = 32'd12345;
        step();
        in_valid = 1'b0;
        n_checks++; if (err_cnt !== 16'd2) begin n_fail++; $display("FAIL err_err_cnt: got %0d expected 2", err_cnt); end
`ifdef DECODE_STICKY_ERR_EN
        n_checks++; if (err_sticky !== 1'b1) begin n_fail++; $display("FAIL err_sticky_set: got %0b expected 1", err_sticky); end
`endif
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            n_checks++; if (out_valid !== 1'b1 || out_idx !== 3'd0 || out_err !== 1'b1) begin
                n_fail++; $display("FAIL err_head[%0d]: got v=%0b idx=%0d err=%0b expected v=1 idx=0 err=1", i, out_valid, out_idx, out_err);
            end
            step();
        end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL err_drain: got %0b expected 0", out_valid); end
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cnt_sel = 3'(i);
            #1;
            n_checks++; if (hit_cnt !== 16'd0) begin n_fail++; $display("FAIL err_hit_cnt[%0d]: got %0d expected 0", i, hit_cnt); end
        end
    endtask

    task automatic test_full();
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            data_in = codes[i];
            step();
        end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready: got %0b expected 0", in_ready); end
        data_in = codes[4];
        cnt_sel = 3'd4;
        step();
        n_checks++; if (hit_cnt !== 16'd0) begin n_fail++; $display("FAIL full_fifth_dropped: got %0d expected 0", hit_cnt); end
        n_checks++; if (out_idx !== 3'd0) begin n_fail++; $display("FAIL full_head_kept: got %0d expected 0", out_idx); end
        out_ready = 1'b1;
        step();
        n_checks++; if (hit_cnt !== 16'd0 || in_ready !== 1'b1 || out_idx !== 3'd1) begin
            n_fail++; $display("FAIL full_pop_only: got hit=%0d rdy=%0b idx=%0d expected hit=0 rdy=1 idx=1", hit_cnt, in_ready, out_idx);
        end
        out_ready = 1'b0;
        step();
        n_checks++; if (hit_cnt !== 16'd1 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL full_push_after: got hit=%0d rdy=%0b expected hit=1 rdy=0", hit_cnt, in_ready);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            n_checks++; if (out_valid !== 1'b1 || out_idx !== 3'(i)) begin
                n_fail++; $display("FAIL full_order[%0d]: got v=%0b idx=%0d expected v=1 idx=%0d", i, out_valid, out_idx, i);
            end
            step();
        end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL full_drain: got %0b expected 0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_zero_drop();
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        data_in   = 32'd0;
        for (int i = 0; i < 10; i++) begin
            step();
            n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL zero_out_valid[%0d]: got %0b expected 0", i, out_valid); end
        end
        in_valid = 1'b0;
        n_checks++; if (err_cnt !== 16'd0) begin n_fail++; $display("FAIL zero_err_cnt: got %0d expected 0", err_cnt); end
        for (int i = 0; i < 8; i++) begin
            cnt_sel = 3'(i);
            #1;
            n_checks++; if (hit_cnt !== 16'd0) begin n_fail++; $display("FAIL zero_hit_cnt[%0d]: got %0d expected 0", i, hit_cnt); end
        end
    endtask

    task automatic test_saturation_and_async_reset();
        do_reset();
        s_cnt_sel   = 3'd3;
        s_out_ready = 1'b1;
        s_in_valid  = 1'b1;
        s_data_in   = 32'd11110111;
        for (int i = 0; i < 5; i++) step();
        s_in_valid = 1'b0;
        step();
        n_checks++; if (s_hit_cnt !== 2'd3) begin n_fail++; $display("FAIL sat_hit_cnt3: got %0d expected 3", s_hit_cnt); end
        n_checks++; if (s_err_cnt !== 2'd0) begin n_fail++; $display("FAIL sat_err_cnt: got %0d expected 0", s_err_cnt); end

        s_out_ready = 1'b0;
        s_in_valid  = 1'b1;
        for (int i = 0; i < 2; i++) step();
        s_in_valid = 1'b0;
        out_ready  = 1'b0;
        in_valid   = 1'b1;
        data_in    = codes[2];
        cnt_sel    = 3'd2;
        step();
        step();
        in_valid = 1'b0;
        n_checks++; if (s_out_valid !== 1'b1 || out_valid !== 1'b1) begin
            n_fail++; $display("FAIL mid_queued: got s_v=%0b v=%0b expected 1 1", s_out_valid, out_valid);
        end
        #5;
        rst = 1'b0;
        #1;
        n_checks++; if (s_out_valid !== 1'b0 || s_in_ready !== 1'b1) begin
            n_fail++; $display("FAIL async_sat_flags: got v=%0b rdy=%0b expected v=0 rdy=1", s_out_valid, s_in_ready);
        end
        n_checks++; if (s_hit_cnt !== 2'd0) begin n_fail++; $display("FAIL async_sat_hit: got %0d expected 0", s_hit_cnt); end
        n_checks++; if (out_valid !== 1'b0 || hit_cnt !== 16'd0) begin
            n_fail++; $display("FAIL async_main: got v=%0b hit=%0d expected v=0 hit=0", out_valid, hit_cnt);
        end
        step();
        rst = 1'b1;
        step();
        n_checks++; if (s_out_valid !== 1'b0 || s_hit_cnt !== 2'd0) begin
            n_fail++; $display("FAIL after_release: got v=%0b hit=%0d expected v=0 hit=0", s_out_valid, s_hit_cnt);
        end
    endtask

    initial begin
        codes[0] = 32'd11111110; codes[1] = 32'd11111101;
        codes[2] = 32'd11111011; codes[3] = 32'd11110111;
        codes[4] = 32'd11101111; codes[5] = 32'd11011111;
        codes[6] = 32'd10111111; codes[7] = 32'd01111111;
        in_valid = 1'b0; out_ready = 1'b0; data_in = '0; cnt_sel = '0;
        s_in_valid = 1'b0; s_out_ready = 1'b0; s_data_in = '0; s_cnt_sel = '0;

        test_reset();
        test_first_push();
        test_back_to_back();
        test_errors();
        test_full();
        test_zero_drop();
        test_saturation_and_async_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
